// File: rtl/ram_seq_ctrl.sv
// Ramp-fill / timed-playback sequencer for an external 1-cycle-latency synchronous RAM.
// Optional PAUSE state on rd_flag during playback is enabled by defining RAM_SEQ_PAUSE_EN.
module ram_seq_ctrl #(
  parameter int          ADDR_W  = 8,
  parameter int          DATA_W  = 8,
  parameter int          DEPTH   = 256,
  parameter logic [23:0] CNT_MAX = 24'd9_999_999,
  parameter int          WR_BASE = 0,
  parameter int          WR_STEP = 1,
  parameter int          LOOP    = 1
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              wr_flag,
  input  logic              rd_flag,
  output logic              ram_wr_en,
  output logic              ram_rd_en,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wr_data,
  input  logic [DATA_W-1:0] ram_rd_data,
  output logic [DATA_W-1:0] disp_data,
  output logic              disp_valid,
  output logic              busy,
  output logic              done
);

  // IDLE | waiting, WRITE | ramp fill, READ | timed playback, PAUSE | playback frozen
  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_PAUSE} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [23:0]         cnt_q, cnt_d;
  logic [DATA_W-1:0]   disp_q, disp_d;
  logic                disp_vld_q, disp_vld_d;
  logic                done_q, done_d;
  logic                busy_q, busy_d;
  logic                wr_en_q, wr_en_d;
  logic                rd_en_q, rd_en_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    disp_d     = disp_q;
    disp_vld_d = 1'b0;
    done_d     = 1'b0;

    // RAM data for the current address is valid one clock after it was presented
    if (state_q == S_READ && cnt_q == 24'd1) begin
      disp_d     = ram_rd_data;
      disp_vld_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (wr_flag) begin
          state_d = S_WRITE;
          addr_d  = '0;
          cnt_d   = '0;
        end else if (rd_flag) begin
          state_d = S_READ;
          addr_d  = '0;
          cnt_d   = '0;
        end
      end
      S_WRITE: begin
        if (addr_q == LAST_ADDR) begin
          state_d = S_IDLE;
          addr_d  = '0;
          done_d  = 1'b1;
        end else begin
          addr_d = addr_q + ADDR_W'(1);
        end
      end
      S_READ: begin
        if (wr_flag) begin
          state_d = S_WRITE;
          addr_d  = '0;
          cnt_d   = '0;
        end
`ifndef RAM_SEQ_PAUSE_EN
        else if (rd_flag) begin
          addr_d = '0;
          cnt_d  = '0;
        end
`endif
        else begin
          if (cnt_q == CNT_MAX) begin
            cnt_d = '0;
            if (addr_q != LAST_ADDR) begin
              addr_d = addr_q + ADDR_W'(1);
            end else if (LOOP != 0) begin
              addr_d = '0;
            end else begin
              state_d = S_IDLE;
              addr_d  = '0;
              done_d  = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 24'd1;
          end
`ifdef RAM_SEQ_PAUSE_EN
          if (rd_flag && state_d == S_READ) state_d = S_PAUSE;
`endif
        end
      end
      S_PAUSE: begin
`ifdef RAM_SEQ_PAUSE_EN
        if (wr_flag) begin
          state_d = S_WRITE;
          addr_d  = '0;
          cnt_d   = '0;
        end else if (rd_flag) begin
          state_d = S_READ;
        end
`else
        state_d = S_IDLE;
        addr_d  = '0;
        cnt_d   = '0;
`endif
      end
      default: begin
        state_d = S_IDLE;
        addr_d  = '0;
        cnt_d   = '0;
      end
    endcase

    busy_d    = (state_d != S_IDLE);
    wr_en_d   = (state_d == S_WRITE);
    rd_en_d   = (state_d == S_READ) || (state_d == S_PAUSE);
    wr_data_d = '0;
    if (state_d == S_WRITE)
      wr_data_d = DATA_W'(WR_BASE) + DATA_W'(addr_d) * DATA_W'(WR_STEP);
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      cnt_q      <= '0;
      disp_q     <= '0;
      disp_vld_q <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      wr_en_q    <= 1'b0;
      rd_en_q    <= 1'b0;
      wr_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      disp_q     <= disp_d;
      disp_vld_q <= disp_vld_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      wr_en_q    <= wr_en_d;
      rd_en_q    <= rd_en_d;
      wr_data_q  <= wr_data_d;
    end
  end

  assign ram_wr_en   = wr_en_q;
  assign ram_rd_en   = rd_en_q;
  assign ram_addr    = addr_q;
  assign ram_wr_data = wr_data_q;
  assign disp_data   = disp_q;
  assign disp_valid  = disp_vld_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_ram_seq_ctrl.sv
// Bench for ram_seq_ctrl: a looping and a single-pass instance share stimulus and are
// compared every cycle against a cycle model; directed scenarios precede random flags/resets.
module tb_ram_seq_ctrl;

  localparam int DEPTH   = 8;
  localparam int CNT_MAX = 3;
  localparam int WR_BASE = 3;
  localparam int WR_STEP = 2;
`ifdef RAM_SEQ_PAUSE_EN
  localparam bit PAUSE_EN = 1'b1;
`else
  localparam bit PAUSE_EN = 1'b0;
`endif
  localparam int ST_I = 0, ST_W = 1, ST_R = 2, ST_P = 3;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;
  logic wr_flag = 1'b0;
  logic rd_flag = 1'b0;

  logic       ram_wr_en0, ram_rd_en0, disp_valid0, busy0, done0;
  logic [7:0] ram_addr0, ram_wr_data0, disp_data0;
  logic [7:0] rd_data0 = 8'h00;
  logic [7:0] ram0 [256] = '{default: 8'h00};

  logic       ram_wr_en1, ram_rd_en1, disp_valid1, busy1, done1;
  logic [7:0] ram_addr1, ram_wr_data1, disp_data1;
  logic [7:0] rd_data1 = 8'h00;
  logic [7:0] ram1 [256] = '{default: 8'h00};

  always #5 sys_clk = ~sys_clk;

  ram_seq_ctrl #(.ADDR_W(8), .DATA_W(8), .DEPTH(DEPTH), .CNT_MAX(24'd3),
                 .WR_BASE(WR_BASE), .WR_STEP(WR_STEP), .LOOP(1)) u_loop (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .wr_flag(wr_flag), .rd_flag(rd_flag),
    .ram_wr_en(ram_wr_en0), .ram_rd_en(ram_rd_en0), .ram_addr(ram_addr0),
    .ram_wr_data(ram_wr_data0), .ram_rd_data(rd_data0), .disp_data(disp_data0),
    .disp_valid(disp_valid0), .busy(busy0), .done(done0));

  ram_seq_ctrl #(.ADDR_W(8), .DATA_W(8), .DEPTH(DEPTH), .CNT_MAX(24'd3),
                 .WR_BASE(WR_BASE), .WR_STEP(WR_STEP), .LOOP(0)) u_once (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .wr_flag(wr_flag), .rd_flag(rd_flag),
    .ram_wr_en(ram_wr_en1), .ram_rd_en(ram_rd_en1), .ram_addr(ram_addr1),
    .ram_wr_data(ram_wr_data1), .ram_rd_data(rd_data1), .disp_data(disp_data1),
    .disp_valid(disp_valid1), .busy(busy1), .done(done1));

  always @(posedge sys_clk) begin
    if (ram_wr_en0) ram0[ram_addr0] <= ram_wr_data0;
    if (ram_rd_en0) rd_data0 <= ram0[ram_addr0];
    if (ram_wr_en1) ram1[ram_addr1] <= ram_wr_data1;
    if (ram_rd_en1) rd_data1 <= ram1[ram_addr1];
  end

  typedef struct {
    int st;
    int addr;
    int cnt;
    int disp;
    bit dv;
    bit done;
  } mdl_t;

  mdl_t m [2];
  int   mmem [2][DEPTH];

  int n_checks = 0;
  int n_errs   = 0;
  int cyc      = 0;
  int wr_cnt0, done_cnt0, done_cnt1;
  int dvq [$];
  int dvt [$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int ramp(input int a);
    return (WR_BASE + a * WR_STEP) % 256;
  endfunction

  task automatic model_step(input int i, input bit wr, input bit rd, input bit rst, input bit loop);
    mdl_t c;
    mdl_t n;
    c = m[i];
    n = c;
    n.dv   = 1'b0;
    n.done = 1'b0;
    if (rst) begin
      m[i] = '{default: 0};
      return;
    end
    case (c.st)
      ST_I: begin
        if (wr)      begin n.st = ST_W; n.addr = 0; n.cnt = 0; end
        else if (rd) begin n.st = ST_R; n.addr = 0; n.cnt = 0; end
      end
      ST_W: begin
        mmem[i][c.addr] = ramp(c.addr);
        if (c.addr == DEPTH - 1) begin n.st = ST_I; n.addr = 0; n.done = 1'b1; end
        else n.addr = c.addr + 1;
      end
      ST_R: begin
        if (c.cnt == 1) begin n.disp = mmem[i][c.addr]; n.dv = 1'b1; end
        if (wr) begin n.st = ST_W; n.addr = 0; n.cnt = 0; end
        else if (rd && !PAUSE_EN) begin n.addr = 0; n.cnt = 0; end
        else begin
          n.cnt = (c.cnt + 1) % (CNT_MAX + 1);
          if (c.cnt == CNT_MAX) begin
            if (c.addr < DEPTH - 1) n.addr = c.addr + 1;
            else if (loop) n.addr = 0;
            else begin n.st = ST_I; n.addr = 0; n.done = 1'b1; end
          end
          if (rd && n.st == ST_R) n.st = ST_P;
        end
      end
      default: begin
        if (wr)      begin n.st = ST_W; n.addr = 0; n.cnt = 0; end
        else if (rd) n.st = ST_R;
      end
    endcase
    m[i] = n;
  endtask

  function automatic logic [28:0] expect_vec(input int i);
    logic w;
    logic r;
    w = (m[i].st == ST_W);
    r = (m[i].st == ST_R) || (m[i].st == ST_P);
    return {w, r, 8'(m[i].addr), w ? 8'(ramp(m[i].addr)) : 8'h00, 8'(m[i].disp),
            m[i].dv, (m[i].st != ST_I), m[i].done};
  endfunction

  function automatic logic [28:0] dut_vec0();
    return {ram_wr_en0, ram_rd_en0, ram_addr0, ram_wr_data0, disp_data0, disp_valid0, busy0, done0};
  endfunction

  function automatic logic [28:0] dut_vec1();
    return {ram_wr_en1, ram_rd_en1, ram_addr1, ram_wr_data1, disp_data1, disp_valid1, busy1, done1};
  endfunction

  task automatic tick(input bit wr, input bit rd, input bit rst);
    wr_flag = wr;
    rd_flag = rd;
    sys_rst = rst;
    @(posedge sys_clk);
    model_step(0, wr, rd, rst, 1'b1);
    model_step(1, wr, rd, rst, 1'b0);
    @(negedge sys_clk);
    cyc++;
    check_eq("loop_outs", 64'(dut_vec0()), 64'(expect_vec(0)));
    check_eq("once_outs", 64'(dut_vec1()), 64'(expect_vec(1)));
    wr_cnt0   += int'(ram_wr_en0);
    done_cnt0 += int'(done0);
    done_cnt1 += int'(done1);
    if (disp_valid0 && dvq.size() < 64) begin
      dvq.push_back(int'(disp_data0));
      dvt.push_back(cyc);
    end
  endtask

  initial begin
    int lim;
    m[0] = '{default: 0};
    m[1] = '{default: 0};

    repeat (3) tick(1'b0, 1'b0, 1'b1);
    check_eq("reset_outs", 64'(dut_vec0()), 64'd0);

    // both flags from IDLE -> WRITE; rd_flag mid-write ignored
    wr_cnt0 = 0; done_cnt0 = 0;
    tick(1'b1, 1'b1, 1'b0);
    repeat (2) tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    repeat (9) tick(1'b0, 1'b0, 1'b0);
    check_eq("wr_en_cycles", 64'(wr_cnt0), 64'd8);
    check_eq("wr_done_pulses", 64'(done_cnt0), 64'd1);
    check_eq("wr_busy_after", 64'(busy0), 64'd0);
    for (int k = 0; k < DEPTH; k++) check_eq("ram_word", 64'(ram0[k]), 64'(3 + 2 * k));

    // playback: LOOP instance wraps, single-pass instance ends on the last word
    dvq.delete(); dvt.delete(); done_cnt1 = 0;
    tick(1'b0, 1'b1, 1'b0);
    repeat (40) tick(1'b0, 1'b0, 1'b0);
    check_eq("dv_count", 64'(dvq.size() >= 9), 64'd1);
    lim = (dvq.size() < 9) ? dvq.size() : 9;
    for (int k = 0; k < lim; k++) check_eq("disp_seq", 64'(dvq[k]), 64'(3 + 2 * (k % 8)));
    for (int k = 1; k < lim; k++) check_eq("dv_spacing", 64'(dvt[k] - dvt[k-1]), 64'd4);
    check_eq("once_done", 64'(done_cnt1), 64'd1);
    check_eq("once_busy", 64'(busy1), 64'd0);
    check_eq("once_disp_hold", 64'(disp_data1), 64'd17);

    // reset mid-playback at address 5
    lim = 0;
    while (ram_addr0 != 8'd5 && lim < 40) begin
      tick(1'b0, 1'b0, 1'b0);
      lim++;
    end
    check_eq("reach_addr5", 64'(ram_addr0), 64'd5);
    tick(1'b0, 1'b0, 1'b1);
    check_eq("midrst_outs", 64'(dut_vec0()), 64'd0);
    tick(1'b0, 1'b1, 1'b0);
    check_eq("restart_addr", 64'(ram_addr0), 64'd0);
    check_eq("restart_rden", 64'(ram_rd_en0), 64'd1);

    // rd_flag at addr 2, cnt 1
    repeat (9) tick(1'b0, 1'b0, 1'b0);
    check_eq("at_addr2", 64'(ram_addr0), 64'd2);
    tick(1'b0, 1'b1, 1'b0);
    if (PAUSE_EN) begin
      repeat (20) tick(1'b0, 1'b0, 1'b0);
      check_eq("pause_addr", 64'(ram_addr0), 64'd2);
      check_eq("pause_rden", 64'(ram_rd_en0), 64'd1);
      tick(1'b0, 1'b1, 1'b0);
      tick(1'b0, 1'b0, 1'b0);
      check_eq("resume_cnt3", 64'(ram_addr0), 64'd2);
      tick(1'b0, 1'b0, 1'b0);
      check_eq("resume_addr3", 64'(ram_addr0), 64'd3);
    end else begin
      check_eq("rd_restart0", 64'(ram_addr0), 64'd0);
      repeat (4) tick(1'b0, 1'b0, 1'b0);
      check_eq("rd_restart1", 64'(ram_addr0), 64'd1);
    end

    // wr_flag aborts playback
    tick(1'b1, 1'b0, 1'b0);
    check_eq("abort_wren", 64'(ram_wr_en0), 64'd1);
    check_eq("abort_addr", 64'(ram_addr0), 64'd0);
    repeat (10) tick(1'b0, 1'b0, 1'b0);

    for (int k = 0; k < 3000; k++) begin
      tick(($urandom % 40) == 0, ($urandom % 30) == 0, ($urandom % 300) == 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/ram_seq_ctrl.md
Name: ram_seq_ctrl

Overview:
Parametrised successor to the single-mode RAM controller in the key/RAM/display chain. It takes debounced write and read pulses from the key filters and fills an external single-port synchronous RAM (1-cycle read latency) with a configurable ramp pattern. It then plays the contents back at a programmable dwell rate, in single-pass or looping mode. The captured read data feeds the 74HC595 seven-segment display driver.

Parameters:
ADDR_W, 8, RAM address width
DATA_W, 8, RAM data width
DEPTH, 256, number of words used (2..2**ADDR_W)
CNT_MAX, 24'd9_999_999, dwell per read address minus 1 (clocks); minimum 2
WR_BASE, 0, ramp start value for write pass
WR_STEP, 1, ramp increment per address
LOOP, 1, 1 = playback wraps forever; 0 = single pass then IDLE

Ports:
sys_clk  in  1  system clock
sys_rst  in  1  synchronous reset, active-high
wr_flag  in  1  one-cycle write-start pulse (from key filter)
rd_flag  in  1  one-cycle read-start pulse (from key filter)
ram_wr_en  out  1  RAM write enable
ram_rd_en  out  1  RAM read enable
ram_addr  out  ADDR_W  RAM address
ram_wr_data  out  DATA_W  RAM write data
ram_rd_data  in  DATA_W  RAM read data, valid 1 clock after ram_addr/ram_rd_en
disp_data  out  DATA_W  latched playback word for display
disp_valid  out  1  one-cycle pulse when disp_data updates
busy  out  1  high in WRITE or READ (and PAUSE)
done  out  1  one-cycle pulse at end of write pass or single-pass read

Behaviour:
- Reset (sys_rst high at a rising edge) takes effect that edge, including mid-operation. Forces state IDLE. All outputs 0, internal counters 0.
- States: IDLE, WRITE, READ (plus PAUSE with macro).
- Priority: wr_flag over rd_flag when both are high in the same cycle.
- IDLE:
  - wr_flag -> WRITE, addr=0.
  - rd_flag -> READ, addr=0, cnt=0.
- WRITE:
  - ram_wr_en=1 for exactly DEPTH consecutive cycles; addr 0..DEPTH-1, one per cycle.
  - ram_wr_data = WR_BASE + addr*WR_STEP, truncated to DATA_W (modulo 2**DATA_W).
  - After addr DEPTH-1 is written: done pulses 1 cycle, state -> IDLE, ram_wr_en=0, addr=0.
  - wr_flag and rd_flag are ignored in WRITE.
- READ:
  - ram_rd_en=1 continuously; ram_wr_en=0.
  - cnt runs 0..CNT_MAX; when cnt==CNT_MAX, addr advances.
  - Sampling: on the cycle cnt==1, disp_data <= ram_rd_data and disp_valid pulses. disp_data therefore updates 2 clocks after the address change.
  - At addr==DEPTH-1 with cnt==CNT_MAX:
    - LOOP=1: addr wraps to 0.
    - LOOP=0: done pulses, state -> IDLE, ram_rd_en=0, addr=0; disp_data holds its last value.
  - rd_flag in READ restarts playback (addr=0, cnt=0) next cycle.
  - wr_flag in READ aborts playback -> WRITE next cycle; disp_data holds.
- busy = (state != IDLE), registered together with the state.
- ram_addr, ram_wr_en, ram_rd_en and ram_wr_data are registered outputs. No combinational path from the flag inputs to any output.

Optional Feature:
RAM_SEQ_PAUSE_EN
- Defined:
  - rd_flag in READ -> PAUSE: cnt and addr frozen, ram_rd_en stays 1, disp_data held.
  - rd_flag in PAUSE -> READ, resuming at the same cnt/addr.
  - wr_flag in PAUSE -> WRITE.
  - busy=1 in PAUSE.
- Not defined: no PAUSE state; rd_flag in READ restarts playback as above.

Test Plan:
- DEPTH=8, WR_BASE=3, WR_STEP=2: wr_flag pulse -> ram_wr_en high 8 cycles, data 3,5,7,9,11,13,15,17 at addr 0..7, then done pulse, busy low.
- Same RAM model, CNT_MAX=3, LOOP=1, rd_flag -> addr changes every 4 clocks; disp_valid every 4 clocks; disp_data sequence 3,5,...,17,3 (wrap observed).
- LOOP=0, CNT_MAX=3 -> after 32 clocks in READ: done pulse, return to IDLE, disp_data stays 17.
- wr_flag and rd_flag in the same cycle from IDLE -> WRITE; rd_flag during WRITE -> no effect, write completes all 8 words.
- sys_rst asserted mid-READ at addr 5 -> next edge: all outputs 0, IDLE; a subsequent rd_flag restarts at addr 0.
- With RAM_SEQ_PAUSE_EN, rd_flag at addr 2 cnt 1 -> addr/cnt frozen 20 cycles; second rd_flag -> resumes at cnt 2, addr 3 after 2 more clocks. Without the macro, the same stimulus restarts at addr 0.
